clks_alot_recovery_seq: RTL

CLKS_ALOT_RECOVERY_SEQ -- requirements
Module: clks_alot_recovery_seq

---
 rtl/clks_alot_recovery_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/clks_alot_recovery_seq.sv
// Bring-up sequencer for a clock-recovery core: clear, init, lock acquisition,
// lock monitoring, bounded retries with backoff, and terminal failure.
module clks_alot_recovery_seq #(
    parameter int CLEAR_CYCLES   = 4,
    parameter int INIT_CYCLES    = 8,
    parameter int LOCK_CYCLES    = 16,
    parameter int LOCK_TIMEOUT   = 64,
    parameter int BACKOFF_CYCLES = 8,
    parameter int MAX_RETRIES    = 2,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [10:0] viol_i,
    input  logic [10:0] viol_mask_i,
    output logic        clear_state_o,
    output logic        init_o,
    output logic        enable_o,
    output logic        recover_o,
    output logic        locked_o,
    output logic        failed_o,
    output logic [2:0]  state_o,
    output logic [1:0]  retry_count_o,
    output logic [11:0] fault_cause_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_INIT    = 3'd2,
        ST_LOCKING = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAULT   = 3'd5,
        ST_FAILED  = 3'd6
    } state_t;

    // Timers compare against the last cycle index so the exit happens on the
    // edge that completes the Nth cycle of the state.
    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] clean_cnt;
    logic [1:0]       retry_cnt;
    logic [11:0]      fault_cause;

    logic [10:0] viol_masked;
    logic        viol_active;
    logic        lock_done;
    logic        lock_timeout;
    logic        fault_event;
    logic [11:0] fault_code;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        viol_masked  = viol_i & ~viol_mask_i;
        viol_active  = |viol_masked;
        lock_done    = (state == ST_LOCKING) && !viol_active && (clean_cnt == LOCK_LAST);
        // Lock completing on the timeout cycle suppresses the timeout.
        lock_timeout = (state == ST_LOCKING) && (timer == TIMEOUT_LAST) && !lock_done;
        fault_event  = lock_timeout || ((state == ST_LOCKED) && viol_active);
        fault_code   = lock_timeout ? 12'h800 : {1'b0, viol_masked};
    end

    // NOTE: every update sits under clk_en, so a deasserted enable freezes all
    // state, timers and counters rather than only the FSM.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            clean_cnt   <= '0;
            retry_cnt   <= '0;
            fault_cause <= '0;
        end else if (clk_en) begin
            timer     <= sat_inc(timer);
            clean_cnt <= '0;
            if (abort_i) begin
                state <= ST_IDLE;
                timer <= '0;
            end else if (fault_event) begin
                fault_cause <= fault_code;
                timer       <= '0;
                if (retry_cnt < RETRY_LIMIT) begin
                    state     <= ST_FAULT;
                    retry_cnt <= retry_cnt + 2'd1;
                end else begin
                    state <= ST_FAILED;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        timer <= '0;
                        if (start_i) begin
                            state       <= ST_CLEAR;
                            retry_cnt   <= '0;
                            fault_cause <= '0;
                        end
                    end
                    ST_CLEAR: if (timer == CLEAR_LAST) begin
                        state <= ST_INIT;
                        timer <= '0;
                    end
                    ST_INIT: if (timer == INIT_LAST) begin
                        state <= ST_LOCKING;
                        timer <= '0;
                    end
                    ST_LOCKING: begin
                        if (lock_done) begin
                            state <= ST_LOCKED;
                            timer <= '0;
                        end else if (!viol_active) begin
                            clean_cnt <= sat_inc(clean_cnt);
                        end
                    end
                    ST_LOCKED: if (!start_i) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                    ST_FAULT: if (timer == BACKOFF_LAST) begin
                        state <= ST_CLEAR;
                        timer <= '0;
                    end
                    ST_FAILED: if (!start_i) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    // NOTE: outputs decode only registered state and timer, so no input has a
    // combinational path to any output.
    assign clear_state_o = (state == ST_CLEAR);
    assign init_o        = (state == ST_INIT) && (timer == '0);
    assign enable_o      = (state == ST_LOCKING) || (state == ST_LOCKED);
    assign recover_o     = enable_o;
    assign locked_o      = (state == ST_LOCKED);
    assign failed_o      = (state == ST_FAILED);
    assign state_o       = state;
    assign retry_count_o = retry_cnt;
    assign fault_cause_o = fault_cause;

endmodule
